pht_predictor: RTL and testbench
================================

Name: pht_predictor

Overview:
- Pattern history table stage directly downstream of the global branch history register (GBH).
- Consumes the 4-bit history `column` and produces a taken/not-taken prediction from a table of 2-bit saturating counters.
- Holds indices of outstanding predictions in a small in-flight queue, so resolution needs only OUTCOME, which is also fed to GBH.
- Sits between fetch (lookup) and execute (resolve) in the RV32IM pipeline.

Parameters:
- HIST_BITS, 4, history width; table has 2**HIST_BITS counters.
- FIFO_DEPTH, 4, maximum outstanding unresolved predictions (power of two).
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- INIT  input  1  synchronous, active-high reset.
- LOOKUP  input  1  prediction request, valid this cycle.
- PC  input  32  branch PC for the lookup.
- column  input  HIST_BITS  current global history from GBH.
- LOOKUP_READY  output  1  queue can accept a lookup.
- PREDICT_VALID  output  1  PREDICT is valid; 1-cycle pulse.
- PREDICT  output  1  predicted direction, 1 = taken.
- RESOLVE  input  1  oldest outstanding branch resolved this cycle.
- OUTCOME  input  1  actual direction, 1 = taken; sampled only with RESOLVE.
- MISPREDICT  output  1  1-cycle pulse: resolved outcome differed from prediction.
- RESOLVE_ERR  output  1  1-cycle pulse: RESOLVE arrived with the queue empty.
- INFLIGHT  output  clog2(FIFO_DEPTH)+1  number of outstanding predictions.

Behaviour:
- Reset (INIT=1 at an edge):
  - All counters set to CTR_INIT and the queue is emptied.
  - PREDICT_VALID, PREDICT, MISPREDICT, RESOLVE_ERR and INFLIGHT go to 0; LOOKUP_READY goes to 1.
  - INIT mid-operation discards any queued entries; no MISPREDICT/RESOLVE_ERR is produced for them.
- Index: idx = column (see Optional Feature).
- Lookup, accepted when LOOKUP && LOOKUP_READY:
  - Next cycle: PREDICT_VALID=1 and PREDICT = ctr[idx][1].
  - {idx, predicted bit} is pushed to the queue tail.
  - A lookup that is not accepted produces no PREDICT_VALID.
- LOOKUP_READY = (INFLIGHT < FIFO_DEPTH). It is combinational from the count only and does not depend on same-cycle RESOLVE.
- Resolve, when RESOLVE and the queue is non-empty:
  - Pop the head {hidx, hpred}.
  - ctr[hidx] saturating-increments if OUTCOME=1, saturating-decrements if OUTCOME=0: 11 stays 11, 00 stays 00.
  - Next cycle: MISPREDICT = (hpred != OUTCOME).
- Resolve with the queue empty: no state change; RESOLVE_ERR=1 next cycle.
- Simultaneous accepted lookup and resolve:
  - Count is unchanged; push and pop both occur.
  - If idx == hidx, the lookup sees the post-update counter (write-first forwarding).
- Queue pointers wrap modulo FIFO_DEPTH; INFLIGHT never exceeds FIFO_DEPTH.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.

Optional Feature:
- Macro PHT_GSHARE_EN.
  - Defined: idx = column ^ PC[HIST_BITS+1:2] (gshare indexing).
  - Undefined: idx = column, and PC is unused.
- All other behaviour is identical in both builds.

Decomposition:
- Package bp_pkg holds:
  - HIST_BITS default;
  - the 2-bit counter typedef and its four encoding constants;
  - sat_update(ctr, taken) function;
  - the queue entry typedef {idx, pred}.
- One sub-module, bp_inflight_fifo: synchronous FIFO with push, pop, full, empty, count and head-data.
  - The counter array and forwarding logic stay in pht_predictor.

Test Plan:
- Reset then lookup with column=4'b0000 -> PREDICT_VALID=1 one cycle later, PREDICT=0, INFLIGHT=1.
- Same index, two lookup/resolve pairs with OUTCOME=1:
  - Counter goes 01->10->11.
  - Third lookup gives PREDICT=1.
  - MISPREDICT pulses on the first resolve only.
- Four lookups without resolve (FIFO_DEPTH=4) -> LOOKUP_READY=0, INFLIGHT=4; a fifth LOOKUP produces no PREDICT_VALID.
  - One RESOLVE -> LOOKUP_READY=1 next cycle.
- RESOLVE with the queue empty -> RESOLVE_ERR pulses one cycle; all counters unchanged; INFLIGHT=0.
- Counter at 10 at idx 4'b0101; lookup idx 4'b0101 in the same cycle as a resolve of that entry with OUTCOME=0 -> PREDICT=0 (forwarded 01), INFLIGHT unchanged.
- PHT_GSHARE_EN build: column=4'b1010, PC=32'h0000_0014 -> idx=4'b1111; verify the update lands on ctr[15].
- INIT asserted with 3 entries queued -> INFLIGHT=0, counters at 01, no MISPREDICT pulse.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor shared types: 2-bit saturating counter, its encodings,
// the update rule and the in-flight queue entry layout.
package bp_pkg;

  localparam int unsigned HIST_BITS = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

  typedef struct packed {
    logic [HIST_BITS-1:0] idx;
    logic                 pred;
  } pht_entry_t;

  // Saturating step toward the resolved direction
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Synchronous FIFO holding outstanding predictions; push is ignored when full
// and pop is ignored when empty. DEPTH must be a power of two (>= 2).
module bp_inflight_fifo #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          head_data_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_c      = (count_q == CW'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign head_data_c = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign push_ok     = push && !full_c;
  assign pop_ok      = pop && !empty_c;

  // Pointer, storage and occupancy next-state; pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pht_predictor.sv
// Pattern history table of 2-bit saturating counters indexed by global
// history, with an in-flight queue so resolution only needs the outcome.
// Optional macro PHT_GSHARE_EN: index = column ^ PC[HIST_BITS+1:2].
module pht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned HIST_BITS  = bp_pkg::HIST_BITS,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic                          CLOCK,
  input  logic                          INIT,
  input  logic                          LOOKUP,
  input  logic [31:0]                   PC,
  input  logic [HIST_BITS-1:0]          column,
  output logic                          LOOKUP_READY,
  output logic                          PREDICT_VALID,
  output logic                          PREDICT,
  input  logic                          RESOLVE,
  input  logic                          OUTCOME,
  output logic                          MISPREDICT,
  output logic                          RESOLVE_ERR,
  output logic [$clog2(FIFO_DEPTH):0]   INFLIGHT
);

  localparam int unsigned TBL_SIZE = 1 << HIST_BITS;
  localparam int unsigned ENTRY_W  = HIST_BITS + 1;

  typedef struct packed {
    logic [HIST_BITS-1:0] idx;
    logic                 pred;
  } entry_t;

  ctr_t   ctr_q [TBL_SIZE];
  ctr_t   ctr_d [TBL_SIZE];
  logic   predict_valid_q, predict_valid_d;
  logic   predict_q, predict_d;
  logic   mispredict_q, mispredict_d;
  logic   resolve_err_q, resolve_err_d;

  logic [HIST_BITS-1:0] idx_c;
  logic                 lookup_acc_c;
  logic                 resolve_acc_c;
  logic                 fifo_full_c;
  logic                 fifo_empty_c;
  logic [ENTRY_W-1:0]   head_raw_c;
  entry_t               head_c;
  entry_t               push_entry_c;
  logic                 unused_pc;

`ifdef PHT_GSHARE_EN
  assign idx_c     = column ^ PC[HIST_BITS+1:2];
  assign unused_pc = ^{PC[31:HIST_BITS+2], PC[1:0]};
`else
  assign idx_c     = column;
  assign unused_pc = ^PC;
`endif

  assign head_c        = entry_t'(head_raw_c);
  assign LOOKUP_READY  = !fifo_full_c;
  assign lookup_acc_c  = LOOKUP && !fifo_full_c;
  assign resolve_acc_c = RESOLVE && !fifo_empty_c;

  bp_inflight_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (CLOCK),
    .rst         (INIT),
    .push        (lookup_acc_c),
    .pop         (resolve_acc_c),
    .push_data   (ENTRY_W'(push_entry_c)),
    .head_data_c (head_raw_c),
    .full_c      (fifo_full_c),
    .empty_c     (fifo_empty_c),
    .count       (INFLIGHT)
  );

  // Counter update on resolve, then lookup reads the updated table (write-first)
  always_comb begin
    ctr_d           = ctr_q;
    predict_valid_d = 1'b0;
    predict_d       = 1'b0;
    mispredict_d    = 1'b0;
    resolve_err_d   = 1'b0;
    push_entry_c    = '0;
    if (resolve_acc_c) begin
      ctr_d[head_c.idx] = sat_update(ctr_q[head_c.idx], OUTCOME);
      mispredict_d      = (head_c.pred != OUTCOME);
    end
    if (RESOLVE && fifo_empty_c) begin
      resolve_err_d = 1'b1;
    end
    if (lookup_acc_c) begin
      predict_valid_d   = 1'b1;
      predict_d         = ctr_d[idx_c][1];
      push_entry_c.idx  = idx_c;
      push_entry_c.pred = ctr_d[idx_c][1];
    end
  end

  // Table and output registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (INIT) begin
      for (int i = 0; i < int'(TBL_SIZE); i++) ctr_q[i] <= CTR_INIT;
      predict_valid_q <= 1'b0;
      predict_q       <= 1'b0;
      mispredict_q    <= 1'b0;
      resolve_err_q   <= 1'b0;
    end else begin
      ctr_q           <= ctr_d;
      predict_valid_q <= predict_valid_d;
      predict_q       <= predict_d;
      mispredict_q    <= mispredict_d;
      resolve_err_q   <= resolve_err_d;
    end
  end

  assign PREDICT_VALID = predict_valid_q;
  assign PREDICT       = predict_q;
  assign MISPREDICT    = mispredict_q;
  assign RESOLVE_ERR   = resolve_err_q;

endmodule

// File: tb/tb_pht_predictor.sv
// Randomized and directed bench for pht_predictor against a table/queue model.
// Honours PHT_GSHARE_EN the same way the design does.
module tb_pht_predictor;

  logic        CLOCK = 1'b0;
  logic        INIT = 1'b0;
  logic        LOOKUP = 1'b0;
  logic [31:0] PC = '0;
  logic [3:0]  column = '0;
  logic        LOOKUP_READY;
  logic        PREDICT_VALID;
  logic        PREDICT;
  logic        RESOLVE = 1'b0;
  logic        OUTCOME = 1'b0;
  logic        MISPREDICT;
  logic        RESOLVE_ERR;
  logic [2:0]  INFLIGHT;

  pht_predictor dut (
    .CLOCK         (CLOCK),
    .INIT          (INIT),
    .LOOKUP        (LOOKUP),
    .PC            (PC),
    .column        (column),
    .LOOKUP_READY  (LOOKUP_READY),
    .PREDICT_VALID (PREDICT_VALID),
    .PREDICT       (PREDICT),
    .RESOLVE       (RESOLVE),
    .OUTCOME       (OUTCOME),
    .MISPREDICT    (MISPREDICT),
    .RESOLVE_ERR   (RESOLVE_ERR),
    .INFLIGHT      (INFLIGHT)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model: counter values as plain ints 0..3, queue of outstanding work
  typedef struct { int idx; bit pred; } pend_t;
  int    m_ctr [16];
  pend_t m_q [$];
  bit    e_pv, e_pred, e_mis, e_err;
  int    e_inf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_idx(input logic [3:0] col, input logic [31:0] pc);
    int r;
    r = int'(col);
`ifdef PHT_GSHARE_EN
    r = r ^ int'((pc >> 2) & 32'hF);
`endif
    if (pc == 32'hFFFF_FFFF) r = r;  // pc only matters for gshare indexing
    return r;
  endfunction

  // One cycle: drive inputs, predict, clock, compare
  task automatic step(input bit init, input bit lk, input logic [3:0] col,
                      input logic [31:0] pc, input bit rs, input bit oc);
    pend_t h;
    int    id;
    @(negedge CLOCK);
    INIT = init; LOOKUP = lk; column = col; PC = pc; RESOLVE = rs; OUTCOME = oc;
    #1;
    if (!init) check("lookup_ready", 32'(LOOKUP_READY), 32'(m_q.size() < 4));
    e_pv = 0; e_pred = 0; e_mis = 0; e_err = 0;
    if (init) begin
      foreach (m_ctr[i]) m_ctr[i] = 1;
      m_q.delete();
    end else begin
      bit ready;
      ready = (m_q.size() < 4);
      if (rs) begin
        if (m_q.size() == 0) e_err = 1;
        else begin
          h = m_q.pop_front();
          if (oc) m_ctr[h.idx] = (m_ctr[h.idx] + 1 > 3) ? 3 : m_ctr[h.idx] + 1;
          else    m_ctr[h.idx] = (m_ctr[h.idx] - 1 < 0) ? 0 : m_ctr[h.idx] - 1;
          e_mis = (h.pred != oc);
        end
      end
      if (lk && ready) begin
        id     = model_idx(col, pc);
        e_pv   = 1;
        e_pred = (m_ctr[id] >= 2);
        m_q.push_back('{idx: id, pred: e_pred});
      end
    end
    e_inf = m_q.size();
    @(posedge CLOCK);
    #1;
    INIT = 0; LOOKUP = 0; RESOLVE = 0;
    check("predict_valid", 32'(PREDICT_VALID), 32'(e_pv));
    if (e_pv) check("predict", 32'(PREDICT), 32'(e_pred));
    check("mispredict", 32'(MISPREDICT), 32'(e_mis));
    check("resolve_err", 32'(RESOLVE_ERR), 32'(e_err));
    check("inflight", 32'(INFLIGHT), 32'(e_inf));
  endtask

  initial begin
    foreach (m_ctr[i]) m_ctr[i] = 1;

    // Reset values
    step(1, 0, 4'h0, 0, 0, 0);
    check("rst_ready", 32'(LOOKUP_READY), 32'd1);
    check("rst_predict", 32'(PREDICT), 32'd0);

    // First lookup: weakly not-taken
    step(0, 1, 4'h0, 0, 0, 0);
    check("first_pred", 32'(PREDICT), 32'd0);
    check("first_inflight", 32'(INFLIGHT), 32'd1);

    // Train idx 0 toward taken twice
    step(0, 0, 4'h0, 0, 1, 1);
    check("train_mis1", 32'(MISPREDICT), 32'd1);
    step(0, 1, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 1);
    check("train_mis2", 32'(MISPREDICT), 32'd0);
    step(0, 1, 4'h0, 0, 0, 0);
    check("train_pred3", 32'(PREDICT), 32'd1);
    step(0, 0, 4'h0, 0, 1, 1);

    // Fill the queue; fifth lookup is refused
    step(1, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'(i + 1), 0, 0, 0);
    check("full_inflight", 32'(INFLIGHT), 32'd4);
    check("full_ready", 32'(LOOKUP_READY), 32'd0);
    step(0, 1, 4'h7, 0, 0, 0);
    check("full_no_pv", 32'(PREDICT_VALID), 32'd0);
    step(0, 0, 4'h0, 0, 1, 0);
    check("drain_ready", 32'(LOOKUP_READY), 32'd1);

    // Resolve with empty queue
    step(1, 0, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 1, 1);
    check("empty_err", 32'(RESOLVE_ERR), 32'd1);
    step(0, 0, 4'h0, 0, 0, 0);
    check("empty_err_pulse", 32'(RESOLVE_ERR), 32'd0);
    step(0, 1, 4'h0, 0, 0, 0);
    check("empty_ctr_kept", 32'(PREDICT), 32'd0);
    step(0, 0, 4'h0, 0, 1, 0);

    // Forwarding: ctr[5]=10, simultaneous lookup + resolve(0) on idx 5
    step(1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 4'h5, 0, 0, 0);
    step(0, 0, 4'h5, 0, 1, 1);
    step(0, 1, 4'h5, 0, 0, 0);
    check("fwd_pre", 32'(PREDICT), 32'd1);
    step(0, 1, 4'h5, 0, 1, 0);
    check("fwd_pred", 32'(PREDICT), 32'd0);
    check("fwd_inflight", 32'(INFLIGHT), 32'd1);

    // Index with PC: train via column 1010 / PC 0x14, probe idx 15 directly
    step(1, 0, 4'h0, 0, 0, 0);
    step(0, 1, 4'hA, 32'h14, 0, 0);
    step(0, 0, 4'h0, 0, 1, 1);
    step(0, 1, 4'hF, 0, 0, 0);
    step(0, 1, 4'hA, 0, 0, 0);

    // Reset with entries queued
    step(1, 0, 4'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h3, 0, 0, 0);
    step(1, 0, 4'h0, 0, 1, 1);
    check("init_inflight", 32'(INFLIGHT), 32'd0);
    check("init_no_mis", 32'(MISPREDICT), 32'd0);
    step(0, 0, 4'h0, 0, 1, 1);
    check("init_err_after", 32'(RESOLVE_ERR), 32'd1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < 60),
           4'($urandom_range(0, 3) == 0 ? 5 : $urandom_range(0, 15)), $urandom(),
           ($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
